// File: rtl/led_pattern_engine.sv
// LED status driver: a programmable prescaler tick drives one of four LED patterns
// (binary count, one-hot chase, PWM breathe, event-activity bar graph).
module led_pattern_engine #(
    parameter int NUM_LEDS   = 8,
    parameter int PRESCALE_W = 26,
    parameter int PWM_W      = 8
) (
    input  logic                clk_100mhz,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [2:0]          rate_sel,
    input  logic                event_pulse,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_COUNT    = 2'd0,
        MODE_CHASE    = 2'd1,
        MODE_BREATHE  = 2'd2,
        MODE_ACTIVITY = 2'd3
    } mode_e;

    localparam int CNT_W = $clog2(NUM_LEDS + 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONES = '1;
    localparam logic [PWM_W-1:0]      DUTY_MAX   = '1;
    localparam logic [NUM_LEDS-1:0]   LED_ONE    = NUM_LEDS'(1);
    localparam logic [CNT_W-1:0]      CNT_SAT    = CNT_W'(NUM_LEDS);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick_q, tick_d;
    mode_e                 mode_q, mode_d;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic [PWM_W-1:0]      duty_q, duty_d;
    logic                  dir_down_q, dir_down_d;
    logic [PWM_W-1:0]      pwm_q, pwm_d;
    logic [CNT_W-1:0]      win_q, win_d;

    logic [PRESCALE_W-1:0] rate_mask;
    logic                  terminal;
    logic                  mode_chg;
    logic [CNT_W-1:0]      win_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] k);
        return (k >= CNT_SAT) ? CNT_SAT : k + 1'b1;
    endfunction

    function automatic logic [NUM_LEDS-1:0] therm(input logic [CNT_W-1:0] k);
        logic [NUM_LEDS-1:0] t;
        for (int i = 0; i < NUM_LEDS; i++) begin
            t[i] = (i < int'(k));
        end
        return t;
    endfunction

    // Returns {direction_down, duty} after one breathe step; reverses at both ends.
    function automatic logic [PWM_W:0] breathe_next(input logic down, input logic [PWM_W-1:0] duty);
        logic [PWM_W:0] r;
        if (!down) begin
            r = (duty == DUTY_MAX) ? {1'b1, duty - 1'b1} : {1'b0, duty + 1'b1};
        end else begin
            r = (duty == '0) ? {1'b0, duty + 1'b1} : {1'b1, duty - 1'b1};
        end
        return r;
    endfunction

    assign rate_mask = PRESC_ONES >> rate_sel;
    assign terminal  = ((presc_q & rate_mask) == rate_mask);
    assign mode_chg  = (mode != mode_q);
    assign win_inc   = event_pulse ? sat_inc(win_q) : win_q;

    always_comb begin
        presc_d    = presc_q;
        tick_d     = 1'b0;
        mode_d     = mode_q;
        led_d      = led_q;
        duty_d     = duty_q;
        dir_down_d = dir_down_q;
        pwm_d      = pwm_q;
        win_d      = win_q;

        if (enable) begin
            presc_d = presc_q + 1'b1;
            pwm_d   = pwm_q + 1'b1;
            tick_d  = terminal;
            // A mode switch swallows any coincident tick: the pattern restarts from its initial state.
            if (mode_chg) begin
                mode_d     = mode_e'(mode);
                duty_d     = '0;
                dir_down_d = 1'b0;
                win_d      = '0;
                led_d      = (mode_e'(mode) == MODE_CHASE) ? LED_ONE : '0;
            end else begin
                case (mode_q)
                    MODE_COUNT: begin
                        if (terminal) led_d = led_q + 1'b1;
                    end
                    MODE_CHASE: begin
                        if (terminal) led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
                    end
                    MODE_BREATHE: begin
                        led_d = (pwm_q < duty_q) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};
                        if (terminal) {dir_down_d, duty_d} = breathe_next(dir_down_q, duty_q);
                    end
                    MODE_ACTIVITY: begin
                        if (terminal) begin
                            led_d = therm(win_inc);
                            win_d = '0;
                        end else begin
                            win_d = win_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            mode_q     <= MODE_COUNT;
            led_q      <= '0;
            duty_q     <= '0;
            dir_down_q <= 1'b0;
            pwm_q      <= '0;
            win_q      <= '0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            mode_q     <= mode_d;
            led_q      <= led_d;
            duty_q     <= duty_d;
            dir_down_q <= dir_down_d;
            pwm_q      <= pwm_d;
            win_q      <= win_d;
        end
    end

    assign led  = led_q;
    assign tick = tick_q;

endmodule
